mod_74x163: RTL and testbench

MOD_74X163 -- requirements
Module: MOD_74x163

---
 rtl/mod_74x163.sv | 25 ++
 tb/tb_mod_74x163.sv | 96 +++++++++
 2 files changed

// File: rtl/mod_74x163.sv
// mod_74x163: synchronous 4-bit binary counter with clear, load and ripple carry
module mod_74x163 (
    input  logic clk,
    input  logic clr_n,
    input  logic load_n,
    input  logic enp,
    input  logic ent,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd,
    output logic rco
);
    logic [3:0] q;
    always_ff @(posedge clk)
        if (!clr_n) q <= 4'd0;
        else if (!load_n) q <= {d, c, b, a};
        else if (enp && ent) q <= q + 4'd1;
    assign {qd, qc, qb, qa} = q;
    assign rco = ent & (q == 4'hf);
endmodule

// File: tb/tb_mod_74x163.sv
// tb_mod_74x163: scoreboard bench for single counter plus an 8-bit cascade
module tb_mod_74x163;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clr_n, load_n, enp, ent, a, b, c, d;
    logic qa, qb, qc, qd, rco;
    logic [3:0] q;
    assign q = {qd, qc, qb, qa};
    mod_74x163 dut (.clk(clk), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
                    .a(a), .b(b), .c(c), .d(d), .qa(qa), .qb(qb), .qc(qc), .qd(qd), .rco(rco));
    logic clr2, enp2, ent2;
    logic l_qa, l_qb, l_qc, l_qd, l_rco, h_qa, h_qb, h_qc, h_qd, h_rco;
    mod_74x163 lo (.clk(clk), .clr_n(clr2), .load_n(1'b1), .enp(enp2), .ent(ent2),
                   .a(1'b0), .b(1'b0), .c(1'b0), .d(1'b0),
                   .qa(l_qa), .qb(l_qb), .qc(l_qc), .qd(l_qd), .rco(l_rco));
    mod_74x163 hi (.clk(clk), .clr_n(clr2), .load_n(1'b1), .enp(enp2), .ent(l_rco),
                   .a(1'b0), .b(1'b0), .c(1'b0), .d(1'b0),
                   .qa(h_qa), .qb(h_qb), .qc(h_qc), .qd(h_qd), .rco(h_rco));
    logic [7:0] cq;
    assign cq = {h_qd, h_qc, h_qb, h_qa, l_qd, l_qc, l_qb, l_qa};
    int vec = 0;
    int bad = 0;
    logic [3:0] mq;
    logic [3:0] exp_q[$];
    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h * Test failed (clr_n=%b load_n=%b enp=%b ent=%b data=%h exp_q=%h)",
                     tag, act, exp, clr_n, load_n, enp, ent, {d, c, b, a}, mq);
        end
    endtask
    task automatic tick(input logic cn, input logic ln, input logic p, input logic t,
                        input logic [3:0] dat);
        @(negedge clk);
        {clr_n, load_n, enp, ent} = {cn, ln, p, t};
        {d, c, b, a} = dat;
        mq = !cn ? 4'd0 : !ln ? dat : (p && t) ? mq + 4'd1 : mq;
        exp_q.push_back(mq);
        @(posedge clk);
        #1;
        check("q", {4'd0, q}, {4'd0, exp_q.pop_front()});
        check("rco", {7'd0, rco}, {7'd0, t && mq == 4'hf});
    endtask
    initial begin
        {clr_n, load_n, enp, ent, a, b, c, d} = 8'hff;
        {clr2, enp2, ent2} = 3'b000;
        mq = 4'd0;
        tick(0, 0, 1, 1, 4'd9);
        tick(1, 0, 0, 0, 4'd5);
        @(negedge clk);
        clr_n = 1'b0;
        #1 check("clr_no_edge", {4'd0, q}, 8'd5);
        clr_n = 1'b1;
        tick(0, 1, 1, 1, 4'd0);
        for (int i = 0; i < 16; i++) tick(1, 1, 1, 1, 4'd0);
        check("wrap", {4'd0, q}, 8'd0);
        tick(1, 0, 0, 0, 4'd3);
        tick(1, 0, 1, 1, 4'd9);
        check("load_pri", {4'd0, q}, 8'd9);
        tick(1, 0, 0, 0, 4'd3);
        tick(0, 0, 1, 1, 4'd9);
        check("clr_pri", {4'd0, q}, 8'd0);
        tick(1, 0, 0, 0, 4'd7);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1, 4'd0);
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 4'd0);
        check("hold7", {4'd0, q}, 8'd7);
        tick(1, 0, 0, 0, 4'hf);
        @(negedge clk);
        ent = 1'b1;
        #1 check("rco_rise", {7'd0, rco}, 8'd1);
        ent = 1'b0;
        #1 check("rco_fall", {7'd0, rco}, 8'd0);
        tick(1, 0, 0, 1, 4'hf);
        tick(1, 1, 1, 1, 4'd0);
        tick(1, 1, 1, 1, 4'd0);
        tick(0, 1, 1, 1, 4'd0);
        tick(1, 1, 1, 1, 4'd0);
        check("clr_release", {4'd0, q}, 8'd1);
        for (int i = 0; i < 8; i++) tick(1, $urandom_range(0, 1) == 0, 1'($urandom), 1'($urandom), 4'($urandom));
        @(negedge clk);
        {clr2, enp2, ent2} = 3'b011;
        @(posedge clk);
        #1 check("casc_clr", cq, 8'd0);
        @(negedge clk);
        clr2 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            check("casc", cq, 8'(i));
            check("casc_rco", {7'd0, h_rco}, {7'd0, i == 255});
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
